// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract: one CW-bit chunk per stage, carry rippled stage to stage.
// Latency STAGES cycles, one op per cycle; whole pipeline freezes while out_valid && !out_ready.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = (STAGES < 1) ? 1 : WIDTH / STAGES;
    localparam int L  = STAGES - 1;

    generate
        if (STAGES < 1 || (WIDTH % CW) != 0 || CW * STAGES != WIDTH) begin : g_bad_params
            $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
        end
    endgenerate

    // Stage registers; a_r/b_r carry the not-yet-consumed operand chunks and the sign bits,
    // s_r accumulates finished result chunks so everything lines up at the last stage.
    logic             v_r [STAGES];
    logic             c_r [STAGES];
    logic [WIDTH-1:0] a_r [STAGES];
    logic [WIDTH-1:0] b_r [STAGES];
    logic [WIDTH-1:0] s_r [STAGES];
    logic             loaded;

    logic             v_i [STAGES];
    logic             c_i [STAGES];
    logic [WIDTH-1:0] a_i [STAGES];
    logic [WIDTH-1:0] b_i [STAGES];
    logic [WIDTH-1:0] s_i [STAGES];
    logic [WIDTH-1:0] s_n [STAGES];
    logic             c_n [STAGES];
    logic [CW:0]      part [STAGES];
    logic             adv;

    assign adv      = !v_r[L] || out_ready;
    assign in_ready = adv;

    always_comb begin
        v_i[0] = in_valid;
        a_i[0] = a;
        b_i[0] = sub ? ~b : b;
        c_i[0] = sub ? 1'b1 : cin;
        s_i[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            v_i[k] = v_r[k-1];
            a_i[k] = a_r[k-1];
            b_i[k] = b_r[k-1];
            c_i[k] = c_r[k-1];
            s_i[k] = s_r[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            part[k] = {1'b0, a_i[k][k*CW +: CW]} + {1'b0, b_i[k][k*CW +: CW]}
                    + {{CW{1'b0}}, c_i[k]};
            s_n[k]  = s_i[k];
            s_n[k][k*CW +: CW] = part[k][CW-1:0];
            c_n[k]  = part[k][CW];
        end
    end

    // Data registers only load behind a valid op so the output flags hold across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_r[k] <= 1'b0;
                c_r[k] <= 1'b0;
                a_r[k] <= '0;
                b_r[k] <= '0;
                s_r[k] <= '0;
            end
            loaded <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                v_r[k] <= v_i[k];
                if (v_i[k]) begin
                    a_r[k] <= a_i[k];
                    b_r[k] <= b_i[k];
                    s_r[k] <= s_n[k];
                    c_r[k] <= c_n[k];
                end
            end
            if (v_i[L]) begin
                loaded <= 1'b1;
            end
        end
    end

    assign out_valid = v_r[L];
    assign sum       = s_r[L];
    assign cout      = c_r[L];
    assign ovf       = (a_r[L][WIDTH-1] == b_r[L][WIDTH-1]) && (s_r[L][WIDTH-1] != a_r[L][WIDTH-1]);
    // Gated by loaded so the flag reads 0 out of reset rather than reflecting the cleared sum.
    assign zero      = loaded && (s_r[L] == '0);

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed cases, random stall traffic, reset, parameter sweep.
module tb_pipelined_adder;

    localparam int DUT_STAGES = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, sub, cin, out_ready;
    logic [31:0] a, b;
    logic        in_ready, out_valid, cout, ovf, zero;
    logic [31:0] sum;

    logic        sw_valid, sw_sub, sw_cin, sw_rdy;
    logic [63:0] sw_a, sw_b;
    logic        ir0, ir1, ir2, ir3, vo0, vo1, vo2, vo3;
    logic        co0, co1, co2, co3, ov0, ov1, ov2, ov3, z0, z1, z2, z3;
    logic [7:0]  s8;
    logic [15:0] s16;
    logic [63:0] s64;
    logic [31:0] s32;

    typedef struct {
        logic [66:0] e;
        int          c;
    } item_t;

    item_t       q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    bit          chk_lat = 1'b0;

    logic [63:0] ta [256];
    logic [63:0] tbv [256];
    logic        tsub [256];
    logic        tcin [256];

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero));

    pipelined_adder #(.WIDTH(8), .STAGES(1)) d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(ir0),
        .a(sw_a[7:0]), .b(sw_b[7:0]), .sub(sw_sub), .cin(sw_cin), .out_valid(vo0),
        .out_ready(sw_rdy), .sum(s8), .cout(co0), .ovf(ov0), .zero(z0));

    pipelined_adder #(.WIDTH(16), .STAGES(2)) d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(ir1),
        .a(sw_a[15:0]), .b(sw_b[15:0]), .sub(sw_sub), .cin(sw_cin), .out_valid(vo1),
        .out_ready(sw_rdy), .sum(s16), .cout(co1), .ovf(ov1), .zero(z1));

    pipelined_adder #(.WIDTH(64), .STAGES(8)) d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(ir2),
        .a(sw_a), .b(sw_b), .sub(sw_sub), .cin(sw_cin), .out_valid(vo2),
        .out_ready(sw_rdy), .sum(s64), .cout(co2), .ovf(ov2), .zero(z2));

    pipelined_adder #(.WIDTH(32), .STAGES(32)) d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(ir3),
        .a(sw_a[31:0]), .b(sw_b[31:0]), .sub(sw_sub), .cin(sw_cin), .out_valid(vo3),
        .out_ready(sw_rdy), .sum(s32), .cout(co3), .ovf(ov3), .zero(z3));

    // Reference: returns {cout, ovf, zero, sum zero-extended to 64 bits} for width w.
    function automatic logic [66:0] ref_fn(input logic [63:0] ra, input logic [63:0] rb,
                                           input logic rsub, input logic rcin, input int w);
        logic [63:0] m, bb, s;
        logic [64:0] full;
        logic        co, ov;
        m    = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        bb   = (rsub ? ~rb : rb) & m;
        full = {1'b0, ra & m} + {1'b0, bb} + {64'd0, (rsub ? 1'b1 : rcin)};
        s    = full[63:0] & m;
        co   = full[w];
        ov   = (ra[w-1] == bb[w-1]) && (s[w-1] != ra[w-1]);
        return {co, ov, (s == 64'd0), s};
    endfunction

    task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle on the main DUT: drive at negedge, sample 1 time unit later, then wait a cycle.
    task automatic tick(input logic v, input logic [31:0] ia, input logic [31:0] ib,
                        input logic isub, input logic icin, input logic ordy,
                        input logic [66:0] e, output logic acc);
        item_t it;
        in_valid  = v;
        a         = ia;
        b         = ib;
        sub       = isub;
        cin       = icin;
        out_ready = ordy;
        #1;
        chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
        if (out_valid && out_ready) begin
            chk("out_without_op", (q.size() > 0), 1);
            if (q.size() > 0) begin
                it = q.pop_front();
                chk("result", {cout, ovf, zero, 32'd0, sum}, it.e);
                if (chk_lat) chk("latency", cyc - it.c, DUT_STAGES);
            end
        end
        acc = v && in_ready;
        if (acc) q.push_back('{e, cyc});
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                        input logic icin, input logic [66:0] e);
        logic acc;
        tick(1'b1, ia, ib, isub, icin, 1'b1, e, acc);
        chk("directed_accept", acc, 1);
    endtask

    task automatic drain(input int budget);
        logic acc;
        int   n;
        n = budget;
        while (q.size() > 0 && n > 0) begin
            tick(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 67'd0, acc);
            n--;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic        acc;
        logic [31:0] ra, rb;
        logic        rs, rc;
        int          guard;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b0;
        sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_sub = 1'b0; sw_cin = 1'b0; sw_rdy = 1'b1;
        #3;
        chk("reset_outputs", {out_valid, cout, ovf, zero, sum}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_reset", in_ready, 1);
        @(negedge clk);

        // Directed cases, back-to-back with out_ready high so latency must be exact.
        chk_lat = 1'b1;
        send(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 64'h0});
        send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, {1'b0, 1'b1, 1'b0, 64'h8000_0000});
        send(32'd5,         32'd7, 1'b1, 1'b0, {1'b0, 1'b0, 1'b0, 64'hFFFF_FFFE});
        send(32'h00FF_FFFF, 32'd1, 1'b0, 1'b0, {1'b0, 1'b0, 1'b0, 64'h0100_0000});
        send(32'hFFFF_FFFE, 32'd0, 1'b0, 1'b1, {1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF});
        send(32'h8000_0000, 32'd1, 1'b1, 1'b0, {1'b1, 1'b1, 1'b0, 64'h7FFF_FFFF});
        send(32'd7,         32'd7, 1'b1, 1'b0, {1'b1, 1'b0, 1'b1, 64'h0});
        send(32'd3,         32'd1, 1'b1, 1'b1, {1'b1, 1'b0, 1'b0, 64'h2});
        drain(20);

        // Random traffic with random backpressure and occasional bubbles.
        chk_lat = 1'b0;
        for (int n = 0; n < 1024; n++) begin
            if ($urandom_range(0, 3) == 0)
                tick(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 67'd0, acc);
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
            acc = 1'b0;
            guard = 0;
            while (!acc && guard < 200) begin
                tick(1'b1, ra, rb, rs, rc, 1'($urandom_range(0, 1)), ref_fn({32'd0, ra}, {32'd0, rb}, rs, rc, 32), acc);
                guard++;
            end
            if (!acc) chk("accept_timeout", acc, 1);
        end
        drain(100);

        // Asynchronous reset with ops in flight and one held at the output.
        for (int n = 0; n < 3; n++)
            tick(1'b1, 32'h1234 + n, 32'd1, 1'b0, 1'b0, 1'b0, ref_fn(64'h1234 + n, 64'd1, 1'b0, 1'b0, 32), acc);
        tick(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 67'd0, acc);
        chk("pre_reset_valid", {out_valid, cout, ovf, zero, sum}, {1'b1, 1'b0, 1'b0, 1'b0, 32'h1235});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {out_valid, cout, ovf, zero, sum}, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 67'd0, acc);
            chk("no_stale_result", out_valid, 0);
        end

        // Parameter sweep: all four instances fed the same stream, out_ready held high.
        for (int i = 0; i < 296; i++) begin
            int          w, s, j;
            logic [67:0] o, e;
            if (i < 256) begin
                ta[i] = {$urandom, $urandom}; tbv[i] = {$urandom, $urandom};
                tsub[i] = 1'($urandom_range(0, 1)); tcin[i] = 1'($urandom_range(0, 1));
                sw_valid = 1'b1; sw_a = ta[i]; sw_b = tbv[i]; sw_sub = tsub[i]; sw_cin = tcin[i];
            end else begin
                sw_valid = 1'b0;
            end
            #1;
            chk("sweep_in_ready", {ir0, ir1, ir2, ir3}, 4'hF);
            for (int d = 0; d < 4; d++) begin
                case (d)
                    0:       begin w = 8;  s = 1;  o = {vo0, co0, ov0, z0, 56'd0, s8};  end
                    1:       begin w = 16; s = 2;  o = {vo1, co1, ov1, z1, 48'd0, s16}; end
                    2:       begin w = 64; s = 8;  o = {vo2, co2, ov2, z2, s64};        end
                    default: begin w = 32; s = 32; o = {vo3, co3, ov3, z3, 32'd0, s32}; end
                endcase
                j = i - s;
                if (j >= 0 && j < 256) begin
                    e = {1'b1, ref_fn(ta[j], tbv[j], tsub[j], tcin[j], w)};
                end else begin
                    e = '0;
                    o = {o[67], 67'd0};
                end
                chk($sformatf("sweep_w%0d_s%0d_t%0d", w, s, i), o, e);
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
